// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI mode-0 master controller.
// Optional build macro used by the top: SPI_MASTER_SEQ_CHECK_EN.
package spi_master_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        M_IDLE,
        M_FRAME,
        M_READ,
        M_GAP
    } mstate_e;

    localparam int FRAME_BITS   = 10;
    localparam int DATA_BITS    = 8;
    localparam int HDR_POSEDGES = 12;

    // MOSI level to present for SCK posedge number nxt (1-based).
    // P1 and P2 both carry the MSB; P3..P12 carry the frame MSB first.
    function automatic logic frame_bit(
        input logic [FRAME_BITS-1:0] f,
        input logic [4:0]            nxt
    );
        logic [3:0] idx;
        idx = 4'(HDR_POSEDGES - int'(nxt));
        if (nxt <= 5'd2)
            return f[FRAME_BITS-1];
        else if (nxt <= 5'(HDR_POSEDGES))
            return f[idx];
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK divider: idle-low serial clock plus one-clk strobes that fire
// on the system edge where SCK rises or falls.
module spi_sck_gen
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_mask_rise,
    output logic o_sck,
    output logic o_rise_pulse,
    output logic o_fall_pulse
);

    localparam int HALF = CLK_DIV / 2;
    localparam int CW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_sck;
    logic          w_tick;

    // A masked rise slot still strobes, so the FSM can use it as a
    // timed "SCK would have risen here" marker without a real edge.
    assign w_tick       = i_en && (r_cnt == CW'(HALF - 1));
    assign o_rise_pulse = w_tick && !r_sck;
    assign o_fall_pulse = w_tick && r_sck;
    assign o_sck        = r_sck;

    // Half-period counter and SCK toggle register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (w_tick) begin
            r_cnt <= '0;
            if (!(o_rise_pulse && i_mask_rise))
                r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: host command port in, 10-bit frames out.
// Build macro SPI_MASTER_SEQ_CHECK_EN adds RD_ADDR/RD_DATA order checking.
module spi_master_ctrl
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int RD_WAIT = 1,
    parameter int GAP_SCK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [7:0] cmd_payload,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
`ifdef SPI_MASTER_SEQ_CHECK_EN
    output logic       cmd_err,
`endif
    output logic       SS_n,
    output logic       SCK,
    output logic       MOSI,
    input  logic       MISO
);

    localparam logic [4:0] LAST_WR = 5'(HDR_POSEDGES);
    localparam logic [4:0] GO_RD   = 5'(HDR_POSEDGES + RD_WAIT - 1);
    localparam logic [4:0] FIRST_D = 5'(HDR_POSEDGES + RD_WAIT + 1);
    localparam logic [4:0] LAST_RD = 5'(HDR_POSEDGES + RD_WAIT + DATA_BITS);
    localparam logic [4:0] GAP_N   = 5'(GAP_SCK);

    mstate_e r_state;
    mstate_e w_state_next;

    logic [FRAME_BITS-1:0] r_frame;
    logic [4:0]            r_pcnt;
    logic                  r_ss_n;
    logic                  r_mosi;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic [DATA_BITS-1:0]  r_rsp_data;

    logic w_sck;
    logic w_rise;
    logic w_fall;
    logic w_sck_en;
    logic w_accept;
    logic w_start;
    logic w_is_rd;
    logic w_end_slot;
    logic w_sample;

`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic r_cmd_err;
    logic r_rd_addr_sent;
    logic w_seq_bad;
`endif

    assign w_is_rd  = (r_frame[9:8] == RD_DATA);
    assign w_sck_en = (r_state != M_IDLE);

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck (
        .clk          (clk),
        .rst          (rst),
        .i_en         (w_sck_en),
        .i_mask_rise  (w_end_slot),
        .o_sck        (w_sck),
        .o_rise_pulse (w_rise),
        .o_fall_pulse (w_fall)
    );

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_start      = 1'b0;
        w_end_slot   = 1'b0;
        w_sample     = 1'b0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
        w_seq_bad    = 1'b0;
`endif
        unique case (r_state)
            M_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_accept = 1'b1;
`ifdef SPI_MASTER_SEQ_CHECK_EN
                    w_seq_bad =
                        ((cmd_type == RD_DATA) && !r_rd_addr_sent) ||
                        ((cmd_type == RD_ADDR) && r_rd_addr_sent);
                    if (!w_seq_bad) begin
                        w_start      = 1'b1;
                        w_state_next = M_FRAME;
                    end
`else
                    w_start      = 1'b1;
                    w_state_next = M_FRAME;
`endif
                end
            end
            M_FRAME: begin
                if (w_rise && w_is_rd && r_pcnt == GO_RD) begin
                    w_state_next = M_READ;
                end else if (w_rise && !w_is_rd && r_pcnt == LAST_WR) begin
                    w_end_slot   = 1'b1;
                    w_state_next = M_GAP;
                end
            end
            M_READ: begin
                if (w_fall && r_pcnt >= FIRST_D)
                    w_sample = 1'b1;
                if (w_rise && r_pcnt == LAST_RD) begin
                    w_end_slot   = 1'b1;
                    w_state_next = M_GAP;
                end
            end
            M_GAP: begin
                if (w_fall && r_pcnt == GAP_N)
                    w_state_next = M_IDLE;
            end
            default: w_state_next = M_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= M_IDLE;
        else
            r_state <= w_state_next;
    end

    // Frame latch, posedge counter, pin drivers and read shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame     <= '0;
            r_pcnt      <= '0;
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_cmd_ready <= (w_state_next == M_IDLE);
            r_rsp_valid <= 1'b0;
            if (w_accept)
                r_frame <= {cmd_type, cmd_payload};
            if (w_start) begin
                r_ss_n <= 1'b0;
                r_mosi <= cmd_type[1];
                r_pcnt <= '0;
            end else if (w_end_slot) begin
                r_ss_n <= 1'b1;
                r_mosi <= 1'b0;
                r_pcnt <= '0;
            end else if (w_rise) begin
                r_pcnt <= r_pcnt + 5'd1;
            end else if (w_fall && r_state != M_GAP) begin
                r_mosi <= frame_bit(r_frame, r_pcnt + 5'd1);
            end
            if (w_sample) begin
                r_rsp_data <= {r_rsp_data[DATA_BITS-2:0], MISO};
                if (r_pcnt == LAST_RD)
                    r_rsp_valid <= 1'b1;
            end
        end
    end

`ifdef SPI_MASTER_SEQ_CHECK_EN
    // Read-sequence tracker: RD_DATA is legal only after an RD_ADDR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_err      <= 1'b0;
            r_rd_addr_sent <= 1'b0;
        end else begin
            r_cmd_err <= w_seq_bad;
            if (w_end_slot && r_frame[9:8] == RD_ADDR)
                r_rd_addr_sent <= 1'b1;
            else if (w_end_slot && w_is_rd)
                r_rd_addr_sent <= 1'b0;
        end
    end

    assign cmd_err = r_cmd_err;
`endif

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != M_IDLE);
    assign SS_n      = r_ss_n;
    assign SCK       = w_sck;
    assign MOSI      = r_mosi;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a small MISO slave model.
// Build with SPI_MASTER_SEQ_CHECK_EN defined to exercise cmd_err.
module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_type = 2'b00;
    logic [7:0] cmd_payload = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       SS_n;
    logic       SCK;
    logic       MOSI;
    logic       MISO = 1'b0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic       cmd_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    int rise_cnt = 0;
    int gap_cnt = 0;
    int rsp_cnt = 0;
    int ready_bad = 0;
    int ss_falls = 0;
    int err_cnt = 0;
    logic mosi_cap [0:31];
    logic [7:0] rsp_last = 8'h00;
    logic [7:0] slave_byte = 8'h00;

    spi_master_ctrl #(
        .CLK_DIV (4),
        .RD_WAIT (1),
        .GAP_SCK (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_type    (cmd_type),
        .cmd_payload (cmd_payload),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .busy        (busy),
`ifdef SPI_MASTER_SEQ_CHECK_EN
        .cmd_err     (cmd_err),
`endif
        .SS_n        (SS_n),
        .SCK         (SCK),
        .MOSI        (MOSI),
        .MISO        (MISO)
    );

    always #5 clk = ~clk;

    // Slave pin model: capture MOSI per posedge, drive MISO for P14..P21.
    always @(posedge SCK) begin
        if (!SS_n) begin
            rise_cnt = rise_cnt + 1;
            if (rise_cnt < 32)
                mosi_cap[rise_cnt] = MOSI;
            if (rise_cnt >= 14 && rise_cnt <= 21)
                MISO = slave_byte[21 - rise_cnt];
            else
                MISO = 1'b0;
        end else begin
            gap_cnt = gap_cnt + 1;
        end
    end

    always @(negedge SS_n) ss_falls = ss_falls + 1;

    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_cnt  = rsp_cnt + 1;
            rsp_last = rsp_data;
        end
        if (busy && cmd_ready)
            ready_bad = ready_bad + 1;
`ifdef SPI_MASTER_SEQ_CHECK_EN
        if (cmd_err)
            err_cnt = err_cnt + 1;
`endif
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    task automatic clear_mon();
        rise_cnt  = 0;
        gap_cnt   = 0;
        rsp_cnt   = 0;
        ready_bad = 0;
        ss_falls  = 0;
        err_cnt   = 0;
        for (int i = 0; i < 32; i++)
            mosi_cap[i] = 1'b0;
    endtask

    function automatic logic [9:0] cap_frame();
        logic [9:0] f;
        f = '0;
        for (int k = 3; k <= 12; k++)
            f[12 - k] = mosi_cap[k];
        return f;
    endfunction

    task automatic send(input logic [1:0] t, input logic [7:0] p);
        bit ok;
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL send_ready: cmd_ready got 0 want 1");
        end
        cmd_type    = t;
        cmd_payload = p;
        cmd_valid   = 1'b1;
        @(negedge clk);
        cmd_valid   = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            if (!busy && cmd_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s_idle: busy got %b want 0", nm, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #23;
        n_cmp++;
        if ({SS_n, SCK, MOSI} !== 3'b100) begin
            n_err++;
            $display("FAIL rst_pins: SS_n/SCK/MOSI got %b want 100",
                     {SS_n, SCK, MOSI});
        end
        n_cmp++;
        if ({cmd_ready, rsp_valid, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_ctl: ready/rsp_valid/busy got %b want 000",
                     {cmd_ready, rsp_valid, busy});
        end
        n_cmp++;
        if (rsp_data !== 8'h00) begin
            n_err++;
            $display("FAIL rst_data: got %h want 00", rsp_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_ready_rise: got %b want 1", cmd_ready);
        end
        clear_mon();
    endtask

    task automatic test_write(input logic [1:0] t, input logic [7:0] p,
                              input logic [9:0] exp, input string nm);
        clear_mon();
        send(t, p);
        wait_idle(nm);
        n_cmp++;
        if (rise_cnt !== 12) begin
            n_err++;
            $display("FAIL %s_rises: got %0d want 12", nm, rise_cnt);
        end
        n_cmp++;
        if (cap_frame() !== exp) begin
            n_err++;
            $display("FAIL %s_bits: got %b want %b", nm, cap_frame(), exp);
        end
        n_cmp++;
        if ({mosi_cap[1], mosi_cap[2]} !== {exp[9], exp[9]}) begin
            n_err++;
            $display("FAIL %s_p1p2: got %b%b want %b%b", nm,
                     mosi_cap[1], mosi_cap[2], exp[9], exp[9]);
        end
        n_cmp++;
        if (gap_cnt !== 1) begin
            n_err++;
            $display("FAIL %s_gap: got %0d want 1", nm, gap_cnt);
        end
        n_cmp++;
        if (rsp_cnt !== 0 || ready_bad !== 0) begin
            n_err++;
            $display("FAIL %s_side: rsp %0d ready_bad %0d want 0 0",
                     nm, rsp_cnt, ready_bad);
        end
    endtask

    task automatic do_read(input logic [7:0] p, input logic [9:0] exp,
                           input logic [7:0] data, input string nm);
        clear_mon();
        slave_byte = data;
        send(2'b11, p);
        wait_idle(nm);
        n_cmp++;
        if (rise_cnt !== 21) begin
            n_err++;
            $display("FAIL %s_rises: got %0d want 21", nm, rise_cnt);
        end
        n_cmp++;
        if (cap_frame() !== exp) begin
            n_err++;
            $display("FAIL %s_bits: got %b want %b", nm, cap_frame(), exp);
        end
        n_cmp++;
        if (mosi_cap[13] !== 1'b0 || mosi_cap[17] !== 1'b0) begin
            n_err++;
            $display("FAIL %s_tail: got %b%b want 00", nm,
                     mosi_cap[13], mosi_cap[17]);
        end
        n_cmp++;
        if (rsp_cnt !== 1) begin
            n_err++;
            $display("FAIL %s_pulses: got %0d want 1", nm, rsp_cnt);
        end
        n_cmp++;
        if (rsp_last !== data) begin
            n_err++;
            $display("FAIL %s_data: got %h want %h", nm, rsp_last, data);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (rsp_data !== data) begin
            n_err++;
            $display("FAIL %s_hold: got %h want %h", nm, rsp_data, data);
        end
    endtask

    task automatic test_read();
        test_write(2'b10, 8'h10, 10'b10_0001_0000, "rdaddr");
        do_read(8'hC3, 10'b11_1100_0011, 8'h5A, "rddata");
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_mon();
        @(negedge clk);
        cmd_type    = 2'b01;
        cmd_payload = 8'h11;
        cmd_valid   = 1'b1;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL b2b_start: busy got 0 want 1");
        end
        cmd_payload = 8'h22;
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_ready: ready %b busy %b want 1 0", ok, busy);
        end
        n_cmp++;
        if (rise_cnt !== 12 || gap_cnt !== 1) begin
            n_err++;
            $display("FAIL b2b_first: rises %0d gaps %0d want 12 1",
                     rise_cnt, gap_cnt);
        end
        n_cmp++;
        if (cap_frame() !== 10'b01_0001_0001) begin
            n_err++;
            $display("FAIL b2b_bits1: got %b want 0100010001", cap_frame());
        end
        n_cmp++;
        if (ready_bad !== 0) begin
            n_err++;
            $display("FAIL b2b_ready_low: got %0d want 0", ready_bad);
        end
        clear_mon();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second_accept: busy got %b want 1", busy);
        end
        cmd_valid = 1'b0;
        wait_idle("b2b");
        n_cmp++;
        if (cap_frame() !== 10'b01_0010_0010 || rise_cnt !== 12) begin
            n_err++;
            $display("FAIL b2b_bits2: got %b/%0d want 0100100010/12",
                     cap_frame(), rise_cnt);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (ss_falls !== 1 || ready_bad !== 0) begin
            n_err++;
            $display("FAIL b2b_extra: falls %0d ready_bad %0d want 1 0",
                     ss_falls, ready_bad);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_mon();
        send(2'b01, 8'hFF);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rise_cnt >= 7) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok || MOSI !== 1'b1 || SCK !== 1'b1) begin
            n_err++;
            $display("FAIL mid_p7: reached %b MOSI %b SCK %b want 1 1 1",
                     ok, MOSI, SCK);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({SS_n, SCK, MOSI, busy, cmd_ready} !== 5'b10000) begin
            n_err++;
            $display("FAIL mid_async: SS_n/SCK/MOSI/busy/ready got %b want 10000",
                     {SS_n, SCK, MOSI, busy, cmd_ready});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (rsp_cnt !== 0) begin
            n_err++;
            $display("FAIL mid_rsp: got %0d want 0", rsp_cnt);
        end
        test_write(2'b00, 8'h3C, 10'b00_0011_1100, "postrst");
    endtask

    task automatic test_seq_check();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
        clear_mon();
        send(2'b11, 8'h00);
        repeat (30) @(negedge clk);
        n_cmp++;
        if (err_cnt !== 1) begin
            n_err++;
            $display("FAIL seq_err: pulses got %0d want 1", err_cnt);
        end
        n_cmp++;
        if (ss_falls !== 0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL seq_noframe: falls %0d busy %b ready %b want 0 0 1",
                     ss_falls, busy, cmd_ready);
        end
`else
        do_read(8'h00, 10'b11_0000_0000, 8'hA3, "rdnoaddr");
`endif
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            mosi_cap[i] = 1'b0;
        test_reset();
        test_write(2'b00, 8'h3C, 10'b00_0011_1100, "wraddr");
        test_write(2'b01, 8'hA5, 10'b01_1010_0101, "wrdata");
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_seq_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
